// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among NUM_REQ requesters.
// A requester that wins with a non-last flit keeps the port until its last flit is written.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy,
    output logic [ID_W-1:0]           owner_id
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            cand_vld;
    logic [ID_W-1:0] cand;
    logic [DATA_W-1:0] flit [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_flit
        assign flit[i] = req_data[i*DATA_W +: DATA_W];
    end

    // (base + k) mod NUM_REQ, valid for k < NUM_REQ; handles non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Candidate: the owner while locked, else the first valid requester from rr_ptr onward.
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        if (state_q == StLocked) begin
            cand     = owner_q;
            cand_vld = req_valid[owner_q];
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!cand_vld && req_valid[wrap_add(rr_ptr_q, k)]) begin
                    cand_vld = 1'b1;
                    cand     = wrap_add(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (fifo_write_en) begin
            case (state_q)
                StIdle: begin
                    if (req_last[cand]) begin
                        rr_ptr_d = wrap_add(cand, 1);
                    end else begin
                        state_d = StLocked;
                        owner_d = cand;
                    end
                end
                StLocked: begin
                    if (req_last[cand]) begin
                        state_d  = StIdle;
                        owner_d  = '0;
                        rr_ptr_d = wrap_add(owner_q, 1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Zero-latency accept: the flit goes to the FIFO on the same edge it is handshaken.
    always_comb begin
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        if (!reset && cand_vld) begin
            req_ready[cand] = ~fifo_full;
            fifo_write_en   = ~fifo_full;
            fifo_data_in    = flit[cand];
        end
        busy     = (state_q == StLocked);
        owner_id = owner_q;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-atomic write arbiter that lets NUM_REQ requesters share one 32-entry x 64-bit network-interface FIFO write port.
- Each requester presents 64-bit flits with a valid/ready handshake and a last-flit marker.
- The arbiter drives the FIFO's write_en/data_in and obeys its full flag.
- Once a requester wins, it owns the port until its last flit is accepted, so packets never interleave in the FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, flit width; matches FIFO data width
ID_W, 2, width of requester index; equals clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester flit valid
req_last  input  NUM_REQ  per-requester last-flit-of-packet marker (qualified by req_valid)
req_data  input  NUM_REQ*DATA_W  flattened flits; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept; flit i transferred when req_valid[i] & req_ready[i]
fifo_full  input  1  FIFO full flag
fifo_write_en  output  1  FIFO write enable
fifo_data_in  output  DATA_W  FIFO write data
busy  output  1  1 while a multi-flit packet holds the lock
owner_id  output  ID_W  index of locking requester; 0 when not busy

Behaviour:
- State: lock state {IDLE, LOCKED}, owner register (ID_W), rr_ptr (ID_W). All registered, synchronous reset.
- Reset values: state=IDLE, owner=0, rr_ptr=0, busy=0, owner_id=0.
  - While reset is high: req_ready=0, fifo_write_en=0, fifo_data_in=0, regardless of inputs.
- Grant selection (combinational):
  - IDLE: candidate = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - LOCKED: candidate = owner, only if req_valid[owner]=1; all other requesters get ready=0.
- Handshake:
  - req_ready[candidate] = ~fifo_full; all other bits 0.
  - No candidate -> req_ready all 0.
  - req_ready depends combinationally on req_valid and fifo_full (zero-latency accept).
- fifo_write_en = req_valid[c] & req_ready[c] for candidate c. fifo_data_in = req_data slice c when a candidate exists, else 0. Zero-cycle latency: the flit is written on the same edge it is accepted.
- Transitions, evaluated only on an accepted flit (fifo_write_en=1):
  - IDLE, accepted flit has req_last=0 -> LOCKED, owner=c; rr_ptr unchanged.
  - IDLE, accepted flit has req_last=1 (single-flit packet) -> stay IDLE, rr_ptr=(c+1) mod NUM_REQ.
  - LOCKED, owner flit with req_last=1 -> IDLE, rr_ptr=(owner+1) mod NUM_REQ, owner=0.
  - LOCKED, owner flit with req_last=0 -> stay LOCKED.
- No accept (fifo_full=1, or no valid candidate): no state change. The lock is held through owner bubbles (req_valid[owner]=0) and through FIFO full.
- busy = (state==LOCKED). owner_id = owner register.
- Requester rules:
  - Must hold req_valid/req_data/req_last stable until accepted.
  - The arbiter never drops or duplicates a flit.
- Wrap-around: rr_ptr increments modulo NUM_REQ; for NUM_REQ not a power of two, rr_ptr=NUM_REQ-1 wraps to 0.
- Reset mid-packet: the lock is abandoned; the next cycle starts from IDLE with rr_ptr=0. The partial packet already in the FIFO is not this block's responsibility.
- fifo_full asserted on the same cycle as a valid request: ready=0 and write_en=0; no FIFO write occurs while full.

Test Plan:
1. Reset then single flits: req_valid=4'b1111, all req_last=1, data i = 64'hA5A5_0000_0000_000i, fifo_full=0 -> write order 0,1,2,3,0; one write per cycle; rr_ptr advances each cycle.
2. Packet atomicity: req1 sends a 3-flit packet (last on 3rd flit) while req0/req2 stay valid -> FIFO receives req1's 3 flits consecutively; busy=1, owner_id=1 after the 1st flit; the next grant goes to req2.
3. Owner bubble: req0 locked, drops req_valid for 2 cycles while req3 is valid -> req_ready[3]=0 and fifo_write_en=0 for those cycles; req0 resumes and completes.
4. Backpressure: fifo_full=1 for 3 cycles mid-packet -> req_ready=0, fifo_write_en=0, state/owner/rr_ptr unchanged; the same flit is written on the first cycle after full deasserts.
5. Reset mid-packet: req2 locked after 1 flit, reset pulses 1 cycle -> busy=0, owner_id=0, rr_ptr=0; with all requesters valid, the next grant goes to req0.
6. Scoreboard soak: random valid/last/full over 2000 cycles with a 32-deep FIFO model -> no interleaving within packets, no lost or duplicated flits, no write while full.
